// File: rtl/literal_apply_if.sv
// Shared DPLL types and the literal-apply request/result bus.
// Literal = variable index plus negation bit; var 0 is the null literal.
package dpll_pkg;
  localparam int NUMBER_CLAUSES = 6;
  localparam int NUMBER_LITS = 3;
  localparam int VAR_BITS = 4;
  localparam int CLEN_W = $clog2(NUMBER_LITS + 1) + 1;
  localparam int FLEN_W = $clog2(NUMBER_CLAUSES + 1) + 1;

  typedef struct packed {
    logic [VAR_BITS-1:0] idx;
    logic                neg;
  } lit_t;

  typedef struct packed {
    logic [CLEN_W-1:0]        len;
    lit_t [NUMBER_LITS-1:0]   lits;
  } clause_t;

  typedef struct packed {
    logic [FLEN_W-1:0]             len;
    clause_t [NUMBER_CLAUSES-1:0]  clauses;
  } formula_t;

  localparam lit_t ZERO_LIT = '0;
  localparam formula_t ZERO_FORMULA = '0;
endpackage

interface literal_apply_if;
  import dpll_pkg::*;
  logic     apply;
  formula_t in_formula;
  lit_t     in_lit;
  logic     ended;
  logic     conflict;
  logic     satisfied;
  formula_t out_formula;

  modport master (
    output apply, in_formula, in_lit,
    input  ended, conflict, satisfied, out_formula
  );
  modport slave (
    input  apply, in_formula, in_lit,
    output ended, conflict, satisfied, out_formula
  );
endinterface

// File: rtl/literal_apply.sv
// Applies a chosen literal to a formula, one clause per clock:
// drops satisfied clauses, deletes falsified literals, compacts.
module literal_apply
  import dpll_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  literal_apply_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  formula_t          form_q, out_q;
  lit_t              lit_q;
  logic [FLEN_W-1:0] i_q, j_q;
  logic              ended_q, conflict_q, satisfied_q;

  clause_t           cur, shr;
  lit_t              negl;
  logic              live, hit, done, kill;
  logic [CLEN_W-1:0] clen, cnt;

  assign bus.ended       = ended_q;
  assign bus.conflict    = conflict_q;
  assign bus.satisfied   = satisfied_q;
  assign bus.out_formula = out_q;

  // Evaluate clause i against the latched literal.
  always_comb begin
    cur  = '0;
    shr  = '0;
    hit  = 1'b0;
    cnt  = '0;
    negl = lit_q;
    negl.neg = ~lit_q.neg;
    live = lit_q.idx != '0;
    for (int c = 0; c < NUMBER_CLAUSES; c++)
      if (FLEN_W'(c) == i_q) cur = form_q.clauses[c];
    clen = (cur.len > CLEN_W'(NUMBER_LITS))
         ? CLEN_W'(NUMBER_LITS) : cur.len;
    for (int m = 0; m < NUMBER_LITS; m++) begin
      if (CLEN_W'(m) < clen) begin
        if (live && cur.lits[m] == lit_q) begin
          hit = 1'b1;
        end else if (!(live && cur.lits[m] == negl)) begin
          for (int p = 0; p < NUMBER_LITS; p++)
            if (CLEN_W'(p) == cnt) shr.lits[p] = cur.lits[m];
          cnt = cnt + CLEN_W'(1);
        end
      end
    end
    shr.len = cnt;
    done = (i_q >= form_q.len)
        || (i_q >= FLEN_W'(NUMBER_CLAUSES));
    kill = !done && !hit && (cnt == '0);
  end

  // Idle/busy sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.apply) state_d = BUSY;
      BUSY:    if (done || kill) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Latch requests, write compacted clauses, publish results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      form_q      <= ZERO_FORMULA;
      out_q       <= ZERO_FORMULA;
      lit_q       <= ZERO_LIT;
      i_q         <= '0;
      j_q         <= '0;
      ended_q     <= 1'b0;
      conflict_q  <= 1'b0;
      satisfied_q <= 1'b0;
    end else begin
      ended_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.apply) begin
            form_q      <= bus.in_formula;
            lit_q       <= bus.in_lit;
            i_q         <= '0;
            j_q         <= '0;
            out_q       <= ZERO_FORMULA;
            conflict_q  <= 1'b0;
            satisfied_q <= 1'b0;
          end
        end
        BUSY: begin
          if (done) begin
            ended_q     <= 1'b1;
            out_q.len   <= j_q;
            satisfied_q <= (j_q == '0);
          end else if (kill) begin
            ended_q    <= 1'b1;
            conflict_q <= 1'b1;
            out_q      <= ZERO_FORMULA;
          end else begin
            if (!hit) begin
              for (int c = 0; c < NUMBER_CLAUSES; c++)
                if (FLEN_W'(c) == j_q) out_q.clauses[c] <= shr;
              j_q <= j_q + FLEN_W'(1);
            end
            i_q <= i_q + FLEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_literal_apply.sv
// Bench for literal_apply: directed cases plus random
// formulas checked against a clause-list reference model.
module tb_literal_apply;
  import dpll_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  literal_apply_if bus();

  literal_apply dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  formula_t fb;

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic lit_t mk(int v);
    lit_t l;
    l.idx = VAR_BITS'(v < 0 ? -v : v);
    l.neg = (v < 0);
    return l;
  endfunction

  task automatic clr();
    fb = '0;
  endtask

  task automatic addc(int n, int a = 0, int b = 0, int c = 0);
    int k;
    k = int'(fb.len);
    fb.clauses[k].len = CLEN_W'(n);
    fb.clauses[k].lits[0] = mk(a);
    fb.clauses[k].lits[1] = mk(b);
    fb.clauses[k].lits[2] = mk(c);
    fb.len = fb.len + 1'b1;
  endtask

  // Reference: walk clauses as literal lists.
  task automatic model(input formula_t f, input lit_t l,
                       output formula_t o, output bit conf,
                       output bit sat, output int lat);
    int n, nc, cl;
    bit hit;
    lit_t neg_l;
    lit_t q[$];
    o = '0; conf = 0; sat = 0; nc = 0;
    neg_l = l;
    neg_l.neg = ~l.neg;
    n = int'(f.len);
    if (n > NUMBER_CLAUSES) n = NUMBER_CLAUSES;
    lat = n + 1;
    for (int k = 0; k < n; k++) begin
      cl = int'(f.clauses[k].len);
      if (cl > NUMBER_LITS) cl = NUMBER_LITS;
      hit = 0;
      q.delete();
      for (int m = 0; m < cl; m++) begin
        if (l.idx != 0 && f.clauses[k].lits[m] == l) hit = 1;
        else if (!(l.idx != 0 && f.clauses[k].lits[m] == neg_l))
          q.push_back(f.clauses[k].lits[m]);
      end
      if (!hit) begin
        if (q.size() == 0) begin
          conf = 1; o = '0; lat = k + 1;
          return;
        end
        o.clauses[nc].len = CLEN_W'(q.size());
        for (int m = 0; m < q.size(); m++)
          o.clauses[nc].lits[m] = q[m];
        nc++;
      end
    end
    o.len = FLEN_W'(nc);
    sat = (nc == 0);
  endtask

  // Called just after the accepting edge.
  task automatic wait_end(input formula_t eo, input bit ec,
                          input bit es, input int elat,
                          input string tag);
    int e;
    bit seen;
    e = 0; seen = 0;
    while (!seen && e < 40) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (bus.ended) seen = 1;
    end
    check({tag, "_ended"}, 128'(seen), 128'(1));
    check({tag, "_lat"}, 128'(e), 128'(elat));
    check({tag, "_conf"}, 128'(bus.conflict), 128'(ec));
    check({tag, "_sat"}, 128'(bus.satisfied), 128'(es));
    check({tag, "_out"}, 128'(bus.out_formula), 128'(eo));
  endtask

  task automatic run_one(input formula_t f, input lit_t l,
                         input string tag);
    formula_t eo;
    bit ec, es;
    int el;
    model(f, l, eo, ec, es, el);
    @(negedge clk);
    bus.apply = 1'b1;
    bus.in_formula = f;
    bus.in_lit = l;
    @(posedge clk);
    #1 bus.apply = 1'b0;
    wait_end(eo, ec, es, el, tag);
    @(negedge clk);
    check({tag, "_pulse"}, 128'(bus.ended), 128'(0));
  endtask

  function automatic formula_t rnd_formula();
    formula_t f;
    int v;
    f = '0;
    for (int c = 0; c < NUMBER_CLAUSES; c++) begin
      f.clauses[c].len = ($urandom_range(0, 9) == 0)
        ? '0 : CLEN_W'($urandom_range(1, 5));
      for (int m = 0; m < NUMBER_LITS; m++) begin
        v = $urandom_range(1, 4);
        f.clauses[c].lits[m] = mk($urandom_range(0, 1) ? -v : v);
      end
    end
    f.len = FLEN_W'($urandom_range(0, 7));
    return f;
  endfunction

  initial begin
    formula_t fa, fb2, eo, eo2;
    bit ec, es, ec2, es2;
    int el, el2, v;
    lit_t l;

    bus.apply = 1'b0;
    bus.in_formula = '0;
    bus.in_lit = '0;

    @(negedge clk);
    check("rst_ended", 128'(bus.ended), 128'(0));
    check("rst_conf", 128'(bus.conflict), 128'(0));
    check("rst_sat", 128'(bus.satisfied), 128'(0));
    check("rst_out", 128'(bus.out_formula), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    clr(); addc(2, 1, -2); addc(2, -1, 3); addc(1, 2);
    fa = fb;
    run_one(fa, mk(1), "shrink");
    check("shrink_len", 128'(bus.out_formula.len), 128'(2));
    check("shrink_c0", 128'(bus.out_formula.clauses[0].lits[0]),
          128'(mk(3)));

    clr(); addc(2, 2, 3); addc(1, -4); addc(1, 5);
    run_one(fb, mk(4), "conflict");

    clr(); addc(1, 1); addc(2, 1, -3);
    run_one(fb, mk(1), "allsat");

    clr();
    run_one(fb, mk(2), "empty");

    clr(); addc(2, 1, 2);
    run_one(fb, ZERO_LIT, "zlit");
    check("zlit_copy", 128'(bus.out_formula), 128'(fb));

    clr(); addc(2, 1, -1); addc(3, 2, -2, 3);
    run_one(fb, mk(2), "both");

    // Apply pulse during a scan must be ignored.
    clr(); addc(2, 1, 2); addc(2, -3, 4); addc(1, 2);
    addc(2, 3, -1);
    fa = fb;
    model(fa, mk(1), eo, ec, es, el);
    @(negedge clk);
    bus.apply = 1'b1;
    bus.in_formula = fa;
    bus.in_lit = mk(1);
    @(posedge clk);
    #1 bus.apply = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.apply = 1'b1;
    bus.in_formula = '0;
    bus.in_lit = mk(3);
    @(posedge clk);
    #1 bus.apply = 1'b0;
    wait_end(eo, ec, es, el - 2, "busy");

    // apply held through ended: next run on the following edge.
    clr(); addc(2, 1, -2); addc(2, -1, 3); addc(1, 2);
    fa = fb;
    clr(); addc(1, 1); addc(2, 1, -3);
    fb2 = fb;
    model(fa, mk(1), eo, ec, es, el);
    model(fb2, mk(1), eo2, ec2, es2, el2);
    @(negedge clk);
    bus.apply = 1'b1;
    bus.in_formula = fa;
    bus.in_lit = mk(1);
    @(posedge clk);
    @(negedge clk);
    bus.in_formula = fb2;
    wait_end(eo, ec, es, el, "b2b_a");
    @(posedge clk);
    #1 bus.apply = 1'b0;
    wait_end(eo2, ec2, es2, el2, "b2b_b");

    // Asynchronous reset in the middle of a 5-clause scan.
    clr(); addc(1, 2); addc(1, 3); addc(1, 4);
    addc(2, -2, 3); addc(2, 2, 4);
    @(negedge clk);
    bus.apply = 1'b1;
    bus.in_formula = fb;
    bus.in_lit = mk(1);
    @(posedge clk);
    #1 bus.apply = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out", 128'(bus.out_formula), 128'(0));
    check("mid_rst_ended", 128'(bus.ended), 128'(0));
    check("mid_rst_conf", 128'(bus.conflict), 128'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_rst_quiet", 128'(bus.ended), 128'(0));
    end
    rst = 1'b0;
    run_one(fb, mk(1), "after_rst");

    for (int t = 0; t < 150; t++) begin
      fa = rnd_formula();
      v = $urandom_range(1, 4);
      l = ($urandom_range(0, 9) == 0)
        ? ZERO_LIT : mk($urandom_range(0, 1) ? -v : v);
      run_one(fa, l, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
